// File: rtl/lif_pkg.sv
// lif_pkg: shared state encoding and default sizing for the LIF neuron core
//   Optional feature macro used by lif_neuron_core: LIF_ADAPTIVE_THRESH_EN
package lif_pkg;
    typedef enum logic [1:0] {INTEG, FIRE, REFRACT} state_t;
    localparam int NUM_PRE_DEF        = 5;
    localparam int W_WIDTH_DEF        = 8;
    localparam int V_WIDTH_DEF        = 12;
    localparam int THRESHOLD_DEF      = 200;
    localparam int LEAK_SHIFT_DEF     = 3;
    localparam int REFRACT_CYCLES_DEF = 4;
    localparam int W_INIT_DEF         = 16;
    localparam int THR_ADJ_STEP       = 16;
endpackage

// File: rtl/lif_weight_bank.sv
// lif_weight_bank: per-synapse weight registers with write port and spike-masked weight sum
//   clk, rst         clock, async active-high reset (weights return to W_INIT)
//   i_spike          presynaptic spike mask selecting which weights are summed
//   i_wr_en/idx/data weight write; indices >= NUM_PRE match no register and are dropped
//   o_sum            sum of weights of active synapses (uses pre-write values this cycle)
module lif_weight_bank
    import lif_pkg::*;
#(
    parameter int NUM_PRE = NUM_PRE_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int W_INIT  = W_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_PRE-1:0] i_spike,
    input  logic               i_wr_en,
    input  logic [2:0]         i_wr_idx,
    input  logic [W_WIDTH-1:0] i_wr_data,
    output logic [W_WIDTH+2:0] o_sum
);
    logic [W_WIDTH-1:0] r_w [NUM_PRE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRE; i++) r_w[i] <= W_WIDTH'(W_INIT);
        end else begin
            for (int i = 0; i < NUM_PRE; i++)
                if (i_wr_en && i_wr_idx == 3'(i)) r_w[i] <= i_wr_data;
        end
    end

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < NUM_PRE; i++)
            if (i_spike[i]) o_sum = o_sum + (W_WIDTH+3)'(r_w[i]);
    end
endmodule

// File: rtl/lif_neuron_core.sv
// lif_neuron_core: leaky integrate-and-fire neuron with refractory period and spike counter
//   clk, rst     clock, async active-high reset
//   pre_spike    presynaptic spikes (ignored outside INTEG)
//   w_wr_*       synaptic weight write port, accepted in every state
//   post_spike   one-cycle fire pulse, one cycle after the threshold crossing
//   refractory   high while in REFRACT
//   v_mem        membrane potential
//   spike_count  wrapping fire counter
//   Define LIF_ADAPTIVE_THRESH_EN to enable the fire-driven adaptive threshold.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int NUM_PRE        = NUM_PRE_DEF,
    parameter int W_WIDTH        = W_WIDTH_DEF,
    parameter int V_WIDTH        = V_WIDTH_DEF,
    parameter int THRESHOLD      = THRESHOLD_DEF,
    parameter int LEAK_SHIFT     = LEAK_SHIFT_DEF,
    parameter int REFRACT_CYCLES = REFRACT_CYCLES_DEF,
    parameter int W_INIT         = W_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_PRE-1:0] pre_spike,
    input  logic               w_wr_en,
    input  logic [2:0]         w_wr_idx,
    input  logic [W_WIDTH-1:0] w_wr_data,
    output logic               post_spike,
    output logic               refractory,
    output logic [V_WIDTH-1:0] v_mem,
    output logic [7:0]         spike_count
);
    localparam int CW = $clog2(REFRACT_CYCLES + 1);

    state_t             r_state;
    logic [CW-1:0]      r_rcnt;
    logic [V_WIDTH-1:0] r_v;
    logic [7:0]         r_cnt;
    logic               r_post;
    logic               r_refr;
    logic [W_WIDTH+2:0] w_sum;
    logic [V_WIDTH:0]   w_v_full;
    logic [V_WIDTH-1:0] w_v_next;
    logic [V_WIDTH-1:0] w_thr_eff;
    logic               w_fire;

    lif_weight_bank #(.NUM_PRE(NUM_PRE), .W_WIDTH(W_WIDTH), .W_INIT(W_INIT)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_spike   (pre_spike),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .o_sum     (w_sum)
    );

    // One spare bit catches overflow so the potential saturates instead of wrapping
    assign w_v_full = {1'b0, r_v} - {1'b0, r_v >> LEAK_SHIFT} + (V_WIDTH+1)'(w_sum);
    assign w_v_next = w_v_full[V_WIDTH] ? '1 : w_v_full[V_WIDTH-1:0];
    assign w_fire   = (r_state == INTEG) && (w_v_next >= w_thr_eff);

`ifdef LIF_ADAPTIVE_THRESH_EN
    logic [7:0]       r_thr_adj;
    logic [V_WIDTH:0] w_thr_full;
    logic [8:0]       w_adj_inc;

    assign w_thr_full = (V_WIDTH+1)'(THRESHOLD) + (V_WIDTH+1)'(r_thr_adj);
    assign w_thr_eff  = w_thr_full[V_WIDTH] ? '1 : w_thr_full[V_WIDTH-1:0];
    assign w_adj_inc  = {1'b0, r_thr_adj} + 9'(THR_ADJ_STEP);

    // Adaptation only relaxes while integrating; it is frozen through FIRE/REFRACT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_thr_adj <= '0;
        else if (w_fire) r_thr_adj <= w_adj_inc[8] ? 8'hFF : w_adj_inc[7:0];
        else if (r_state == INTEG && r_thr_adj != 8'd0) r_thr_adj <= r_thr_adj - 8'd1;
    end
`else
    assign w_thr_eff = V_WIDTH'(THRESHOLD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INTEG;
            r_rcnt  <= '0;
            r_v     <= '0;
            r_cnt   <= '0;
            r_post  <= 1'b0;
            r_refr  <= 1'b0;
        end else begin
            r_post <= 1'b0;
            case (r_state)
                INTEG: begin
                    if (w_fire) begin
                        r_state <= FIRE;
                        r_post  <= 1'b1;
                        r_v     <= '0;
                        r_cnt   <= r_cnt + 8'd1;
                    end else begin
                        r_v <= w_v_next;
                    end
                end
                FIRE: begin
                    r_state <= REFRACT;
                    r_refr  <= 1'b1;
                    r_rcnt  <= CW'(REFRACT_CYCLES - 1);
                end
                REFRACT: begin
                    if (r_rcnt == '0) begin
                        r_state <= INTEG;
                        r_refr  <= 1'b0;
                    end else begin
                        r_rcnt <= r_rcnt - CW'(1);
                    end
                end
                default: r_state <= INTEG;
            endcase
        end
    end

    assign post_spike  = r_post;
    assign refractory  = r_refr;
    assign v_mem       = r_v;
    assign spike_count = r_cnt;
endmodule

// File: tb/tb_lif_neuron_core.sv
// tb_lif_neuron_core: directed self-checking bench for lif_neuron_core (default build)
module tb_lif_neuron_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pre_spike;
    logic        w_wr_en;
    logic [2:0]  w_wr_idx;
    logic [7:0]  w_wr_data;
    logic        post_spike;
    logic        refractory;
    logic [11:0] v_mem;
    logic [7:0]  spike_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lif_neuron_core dut (
        .clk         (clk),
        .rst         (rst),
        .pre_spike   (pre_spike),
        .w_wr_en     (w_wr_en),
        .w_wr_idx    (w_wr_idx),
        .w_wr_data   (w_wr_data),
        .post_spike  (post_spike),
        .refractory  (refractory),
        .v_mem       (v_mem),
        .spike_count (spike_count)
    );

    typedef struct {
        logic [4:0] pre;
        int         v;
        bit         post;
        bit         refr;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] p, input logic we, input logic [2:0] idx, input logic [7:0] d);
        pre_spike = p;
        w_wr_en   = we;
        w_wr_idx  = idx;
        w_wr_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'b0, 1'b0, 3'd0, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fire(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (post_spike) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        int fires;
        tbl[0]  = '{5'b00001, 16,  1'b0, 1'b0};
        tbl[1]  = '{5'b00001, 30,  1'b0, 1'b0};
        tbl[2]  = '{5'b00001, 43,  1'b0, 1'b0};
        tbl[3]  = '{5'b00001, 54,  1'b0, 1'b0};
        tbl[4]  = '{5'b00001, 64,  1'b0, 1'b0};
        tbl[5]  = '{5'b00001, 72,  1'b0, 1'b0};
        tbl[6]  = '{5'b11111, 143, 1'b0, 1'b0};
        tbl[7]  = '{5'b11111, 0,   1'b1, 1'b0};
        tbl[8]  = '{5'b11111, 0,   1'b0, 1'b1};
        tbl[9]  = '{5'b11111, 0,   1'b0, 1'b1};
        tbl[10] = '{5'b11111, 0,   1'b0, 1'b1};
        tbl[11] = '{5'b11111, 0,   1'b0, 1'b1};
        tbl[12] = '{5'b11111, 0,   1'b0, 1'b0};
        tbl[13] = '{5'b00010, 16,  1'b0, 1'b0};

        drive(5'b0, 1'b0, 3'd0, 8'd0);
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_post", int'(post_spike), 0);
        chk("rst_refr", int'(refractory), 0);
        chk("rst_v", int'(v_mem), 0);
        chk("rst_cnt", int'(spike_count), 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pre, 1'b0, 3'd0, 8'd0);
            tick();
            chk($sformatf("vec%0d_v", i), int'(v_mem), tbl[i].v);
            chk($sformatf("vec%0d_post", i), int'(post_spike), int'(tbl[i].post));
            chk($sformatf("vec%0d_refr", i), int'(refractory), int'(tbl[i].refr));
        end
        chk("vec_cnt", int'(spike_count), 1);

        do_reset();
        drive(5'b00100, 1'b1, 3'd2, 8'd100);
        tick();
        chk("haz_old_w", int'(v_mem), 16);
        drive(5'b00100, 1'b0, 3'd0, 8'd0);
        tick();
        chk("haz_new_w", int'(v_mem), 114);
        drive(5'b00000, 1'b1, 3'd6, 8'd200);
        tick();
        chk("haz_leak", int'(v_mem), 100);
        drive(5'b00001, 1'b0, 3'd0, 8'd0);
        tick();
        chk("haz_idx6_w0", int'(v_mem), 104);
        drive(5'b11011, 1'b0, 3'd0, 8'd0);
        tick();
        chk("haz_idx6_rest", int'(v_mem), 155);

        do_reset();
        drive(5'b00000, 1'b1, 3'd0, 8'd199);
        tick();
        drive(5'b00001, 1'b0, 3'd0, 8'd0);
        tick();
        chk("thr_m1_v", int'(v_mem), 199);
        chk("thr_m1_post", int'(post_spike), 0);
        drive(5'b00000, 1'b0, 3'd0, 8'd0);
        tick();
        chk("thr_m1_leak", int'(v_mem), 175);

        do_reset();
        drive(5'b00000, 1'b1, 3'd0, 8'd200);
        tick();
        drive(5'b00001, 1'b0, 3'd0, 8'd0);
        tick();
        chk("thr_eq_post", int'(post_spike), 1);
        chk("thr_eq_v", int'(v_mem), 0);
        tick();
        chk("thr_eq_refr", int'(refractory), 1);
        chk("thr_eq_pulse", int'(post_spike), 0);
        drive(5'b00001, 1'b1, 3'd0, 8'd50);
        tick();
        chk("refr_wr_v", int'(v_mem), 0);
        drive(5'b00001, 1'b0, 3'd0, 8'd0);
        tick();
        tick();
        chk("refr_last", int'(refractory), 1);
        tick();
        chk("refr_exit", int'(refractory), 0);
        chk("refr_exit_v", int'(v_mem), 0);
        tick();
        chk("refr_wr_used", int'(v_mem), 50);

        do_reset();
        drive(5'b00000, 1'b1, 3'd0, 8'd255);
        tick();
        drive(5'b00001, 1'b0, 3'd0, 8'd0);
        fires = 0;
        ok = 1'b1;
        while (ok && fires < 255) begin
            wait_fire(ok);
            if (ok) fires++;
        end
        chk("wrap_timeout", int'(ok), 1);
        chk("wrap_255", int'(spike_count), 255);
        wait_fire(ok);
        chk("wrap_timeout2", int'(ok), 1);
        chk("wrap_0", int'(spike_count), 0);
        tick();
        tick();
        chk("arst_pre_refr", int'(refractory), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_refr", int'(refractory), 0);
        chk("arst_v", int'(v_mem), 0);
        chk("arst_cnt", int'(spike_count), 0);
        rst = 1'b0;
        tick();
        chk("arst_integ_w", int'(v_mem), 16);
        chk("arst_integ_refr", int'(refractory), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
